ex_stage: RTL and testbench

Execute pipeline stage that sits directly upstream of the ALU in the MIPS core and consumes what it produces.
- Registers decoded operands (ID/EX slot), resolves RAW hazards by forwarding, and drives the internal alu instance.
- Captures the ALU result into an EX/MEM output register.
- valid/ready handshake on both sides gives single-cycle throughput and correct stalling and flushing.

---
 rtl/ex_stage_pkg.sv | 18 +
 rtl/ex_stage_if.sv | 53 +++++
 rtl/alu.sv | 33 +++
 rtl/ex_fwd_sel.sv | 32 +++
 rtl/ex_stage.sv | 146 ++++++++++++++
 tb/tb_ex_stage.sv | 313 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ex_stage_pkg.sv
// Shared ALU definitions for the execute stage and the alu.
// Holds the ALUOP_* command codes and the op width.
package ex_stage_pkg;

    localparam int ALU_OP_W = 4;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALUOP_ADD  = 4'd0;
    localparam alu_op_t ALUOP_SUB  = 4'd1;
    localparam alu_op_t ALUOP_AND  = 4'd2;
    localparam alu_op_t ALUOP_OR   = 4'd3;
    localparam alu_op_t ALUOP_XOR  = 4'd4;
    localparam alu_op_t ALUOP_NOR  = 4'd5;
    localparam alu_op_t ALUOP_SLT  = 4'd6;
    localparam alu_op_t ALUOP_SLTU = 4'd7;

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of the execute-stage signals: ID offer, flush, MEM/WB
// forward sources and the EX/MEM result. slave = stage, master = env.
interface ex_stage_if
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid_i;
    logic                  id_ready_o;
    alu_op_t               id_alu_op_i;
    logic [REG_ADDR_W-1:0] id_rs_addr_i;
    logic [REG_ADDR_W-1:0] id_rt_addr_i;
    logic [DATA_W-1:0]     id_rs_data_i;
    logic [DATA_W-1:0]     id_rt_data_i;
    logic [DATA_W-1:0]     id_imm_i;
    logic                  id_use_imm_i;
    logic [REG_ADDR_W-1:0] id_rd_addr_i;
    logic                  id_reg_write_i;
    logic                  flush_i;
    logic                  mem_reg_write_i;
    logic [REG_ADDR_W-1:0] mem_rd_addr_i;
    logic [DATA_W-1:0]     mem_result_i;
    logic                  wb_reg_write_i;
    logic [REG_ADDR_W-1:0] wb_rd_addr_i;
    logic [DATA_W-1:0]     wb_result_i;
    logic                  ex_valid_o;
    logic                  ex_ready_i;
    logic [DATA_W-1:0]     ex_result_o;
    logic [DATA_W-1:0]     ex_rt_data_o;
    logic [REG_ADDR_W-1:0] ex_rd_addr_o;
    logic                  ex_reg_write_o;

    modport slave (
        input  id_valid_i, id_alu_op_i, id_rs_addr_i, id_rt_addr_i,
        input  id_rs_data_i, id_rt_data_i, id_imm_i, id_use_imm_i,
        input  id_rd_addr_i, id_reg_write_i, flush_i,
        input  mem_reg_write_i, mem_rd_addr_i, mem_result_i,
        input  wb_reg_write_i, wb_rd_addr_i, wb_result_i, ex_ready_i,
        output id_ready_o, ex_valid_o, ex_result_o, ex_rt_data_o,
        output ex_rd_addr_o, ex_reg_write_o
    );

    modport master (
        output id_valid_i, id_alu_op_i, id_rs_addr_i, id_rt_addr_i,
        output id_rs_data_i, id_rt_data_i, id_imm_i, id_use_imm_i,
        output id_rd_addr_i, id_reg_write_i, flush_i,
        output mem_reg_write_i, mem_rd_addr_i, mem_result_i,
        output wb_reg_write_i, wb_rd_addr_i, wb_result_i, ex_ready_i,
        input  id_ready_o, ex_valid_o, ex_result_o, ex_rt_data_o,
        input  ex_rd_addr_o, ex_reg_write_o
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU: result = param_1 <alu_op> param_2, modulo 2^DATA_W.
// Ports: alu_op command, param_1/param_2 operands, result.
module alu
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_t           alu_op,
    input  logic [DATA_W-1:0] param_1,
    input  logic [DATA_W-1:0] param_2,
    output logic [DATA_W-1:0] result
);
    logic slt_s;
    logic slt_u;

    assign slt_s = $signed(param_1) < $signed(param_2);
    assign slt_u = param_1 < param_2;

    always_comb begin
        result = '0;
        case (alu_op)
            ALUOP_ADD:  result = param_1 + param_2;
            ALUOP_SUB:  result = param_1 - param_2;
            ALUOP_AND:  result = param_1 & param_2;
            ALUOP_OR:   result = param_1 | param_2;
            ALUOP_XOR:  result = param_1 ^ param_2;
            ALUOP_NOR:  result = ~(param_1 | param_2);
            ALUOP_SLT:  result = {{(DATA_W-1){1'b0}}, slt_s};
            ALUOP_SLTU: result = {{(DATA_W-1){1'b0}}, slt_u};
            default:    result = '0;
        endcase
    end
endmodule

// File: rtl/ex_fwd_sel.sv
// Priority forward select for one source operand: EX/MEM slot,
// then MEM, then WB, else register-file data. r0 never forwards.
module ex_fwd_sel #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic [DATA_W-1:0]     rf_data,
    input  logic                  b_en,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0]     b_data,
    input  logic                  mem_en,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     data
);
    always_comb begin
        data = rf_data;
        if (src != '0) begin
            if (b_en && b_addr == src) begin
                data = b_data;
            end else if (mem_en && mem_addr == src) begin
                data = mem_data;
            end else if (wb_en && wb_addr == src) begin
                data = wb_data;
            end
        end
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX slot A with RAW forwarding into the alu,
// EX/MEM slot B holding the result. Ports: clk_i, rst_i, bus (slave).
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic       clk_i,
    input logic       rst_i,
    ex_stage_if.slave bus
);
    logic                  a_valid;
    alu_op_t               a_op;
    logic [REG_ADDR_W-1:0] a_rs_addr;
    logic [REG_ADDR_W-1:0] a_rt_addr;
    logic [DATA_W-1:0]     a_rs_data;
    logic [DATA_W-1:0]     a_rt_data;
    logic [DATA_W-1:0]     a_imm;
    logic                  a_use_imm;
    logic [REG_ADDR_W-1:0] a_rd_addr;
    logic                  a_reg_write;

    logic                  b_valid;
    logic [DATA_W-1:0]     b_result;
    logic [DATA_W-1:0]     b_rt_data;
    logic [REG_ADDR_W-1:0] b_rd_addr;
    logic                  b_reg_write;

    logic                  can_load_b;
    logic                  id_ready;
    logic                  accept;
    logic                  move;
    logic                  b_fwd;
    logic [DATA_W-1:0]     fwd_rs;
    logic [DATA_W-1:0]     fwd_rt;
    logic [DATA_W-1:0]     op2;
    logic [DATA_W-1:0]     alu_res;

    assign can_load_b = !b_valid || bus.ex_ready_i;
    assign id_ready   = !a_valid || can_load_b;
    assign accept     = bus.id_valid_i && id_ready;
    // A flush kills slot A before it can advance into B.
    assign move       = can_load_b && a_valid && !bus.flush_i;
    assign b_fwd      = b_valid && b_reg_write;

    ex_fwd_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
        .src      (a_rs_addr),
        .rf_data  (a_rs_data),
        .b_en     (b_fwd),
        .b_addr   (b_rd_addr),
        .b_data   (b_result),
        .mem_en   (bus.mem_reg_write_i),
        .mem_addr (bus.mem_rd_addr_i),
        .mem_data (bus.mem_result_i),
        .wb_en    (bus.wb_reg_write_i),
        .wb_addr  (bus.wb_rd_addr_i),
        .wb_data  (bus.wb_result_i),
        .data     (fwd_rs)
    );

    ex_fwd_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
        .src      (a_rt_addr),
        .rf_data  (a_rt_data),
        .b_en     (b_fwd),
        .b_addr   (b_rd_addr),
        .b_data   (b_result),
        .mem_en   (bus.mem_reg_write_i),
        .mem_addr (bus.mem_rd_addr_i),
        .mem_data (bus.mem_result_i),
        .wb_en    (bus.wb_reg_write_i),
        .wb_addr  (bus.wb_rd_addr_i),
        .wb_data  (bus.wb_result_i),
        .data     (fwd_rt)
    );

    assign op2 = a_use_imm ? a_imm : fwd_rt;

    alu #(.DATA_W(DATA_W)) u_alu (
        .alu_op  (a_op),
        .param_1 (fwd_rs),
        .param_2 (op2),
        .result  (alu_res)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_valid <= 1'b0;
        end else if (bus.flush_i) begin
            a_valid <= 1'b0;
        end else if (accept) begin
            a_valid <= 1'b1;
        end else if (move) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_op        <= '0;
            a_rs_addr   <= '0;
            a_rt_addr   <= '0;
            a_rs_data   <= '0;
            a_rt_data   <= '0;
            a_imm       <= '0;
            a_use_imm   <= 1'b0;
            a_rd_addr   <= '0;
            a_reg_write <= 1'b0;
        end else if (accept) begin
            a_op        <= bus.id_alu_op_i;
            a_rs_addr   <= bus.id_rs_addr_i;
            a_rt_addr   <= bus.id_rt_addr_i;
            a_rs_data   <= bus.id_rs_data_i;
            a_rt_data   <= bus.id_rt_data_i;
            a_imm       <= bus.id_imm_i;
            a_use_imm   <= bus.id_use_imm_i;
            a_rd_addr   <= bus.id_rd_addr_i;
            a_reg_write <= bus.id_reg_write_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_valid     <= 1'b0;
            b_result    <= '0;
            b_rt_data   <= '0;
            b_rd_addr   <= '0;
            b_reg_write <= 1'b0;
        end else if (can_load_b) begin
            b_valid <= move;
            if (move) begin
                b_result    <= alu_res;
                b_rt_data   <= fwd_rt;
                b_rd_addr   <= a_rd_addr;
                b_reg_write <= a_reg_write;
            end
        end
    end

    assign bus.id_ready_o     = id_ready;
    assign bus.ex_valid_o     = b_valid;
    assign bus.ex_result_o    = b_result;
    assign bus.ex_rt_data_o   = b_rt_data;
    assign bus.ex_rd_addr_o   = b_rd_addr;
    assign bus.ex_reg_write_o = b_reg_write;
endmodule

// File: tb/tb_ex_stage.sv
// Random and directed checks of ex_stage against a program-order
// architectural model with a surrounding MEM/WB/register-file env.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic [DW-1:0] imm;
        logic          use_imm;
        logic          we;
    } instr_t;

    typedef struct {
        logic [DW-1:0] res;
        logic [DW-1:0] rtd;
        logic [AW-1:0] rd;
        logic          we;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

    ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] arch   [32];
    logic [DW-1:0] env_rf [32];
    res_t mem_s;
    res_t wb_s;
    res_t bub;
    bit     m_a;
    bit     m_b;
    instr_t a_ins;
    res_t   b_res;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] alu_ref(input logic [3:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            ALUOP_ADD:  return a + b;
            ALUOP_SUB:  return a - b;
            ALUOP_AND:  return a & b;
            ALUOP_OR:   return a | b;
            ALUOP_XOR:  return a ^ b;
            ALUOP_NOR:  return ~(a | b);
            ALUOP_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
            ALUOP_SLTU: return (a < b) ? 1 : 0;
            default:    return '0;
        endcase
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input int rs,
                                  input int rt, input int rd,
                                  input logic [DW-1:0] imm,
                                  input bit use_imm, input bit we);
        instr_t i;
        i.op = op;
        i.rs = AW'(rs);
        i.rt = AW'(rt);
        i.rd = AW'(rd);
        i.imm = imm;
        i.use_imm = use_imm;
        i.we = we;
        return i;
    endfunction

    // Register file with write-before-read of the WB stage.
    function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] idx);
        if (idx != 0 && wb_s.we && wb_s.rd == idx) return wb_s.res;
        return env_rf[idx];
    endfunction

    // Program-order execution on the architectural register file.
    function automatic res_t execute(input instr_t i);
        res_t r;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = arch[i.rs];
        b = arch[i.rt];
        r.res = alu_ref(i.op, a, i.use_imm ? i.imm : b);
        r.rtd = b;
        r.rd = i.rd;
        r.we = i.we;
        if (i.we && i.rd != 0) arch[i.rd] = r.res;
        return r;
    endfunction

    task automatic step(input bit v, input instr_t ins, input bit fl,
                        input bit rdy, output bit fired);
        bit exp_ready;
        bit fire_ex;
        bit can_b;
        bit moved;
        bus.id_valid_i      = v;
        bus.id_alu_op_i     = ins.op;
        bus.id_rs_addr_i    = ins.rs;
        bus.id_rt_addr_i    = ins.rt;
        bus.id_rs_data_i    = rf_read(ins.rs);
        bus.id_rt_data_i    = rf_read(ins.rt);
        bus.id_imm_i        = ins.imm;
        bus.id_use_imm_i    = ins.use_imm;
        bus.id_rd_addr_i    = ins.rd;
        bus.id_reg_write_i  = ins.we;
        bus.flush_i         = fl;
        bus.ex_ready_i      = rdy;
        bus.mem_reg_write_i = mem_s.we;
        bus.mem_rd_addr_i   = mem_s.rd;
        bus.mem_result_i    = mem_s.res;
        bus.wb_reg_write_i  = wb_s.we;
        bus.wb_rd_addr_i    = wb_s.rd;
        bus.wb_result_i     = wb_s.res;
        @(negedge clk);
        exp_ready = !m_a || !m_b || rdy;
        chk("id_ready", DW'(bus.id_ready_o), DW'(exp_ready));
        chk("ex_valid", DW'(bus.ex_valid_o), DW'(m_b));
        if (m_b) begin
            chk("ex_result", bus.ex_result_o, b_res.res);
            chk("ex_rt_data", bus.ex_rt_data_o, b_res.rtd);
            chk("ex_rd", DW'(bus.ex_rd_addr_o), DW'(b_res.rd));
            chk("ex_we", DW'(bus.ex_reg_write_o), DW'(b_res.we));
        end
        fire_ex = m_b && rdy;
        fired = v && exp_ready;
        @(posedge clk);
        #1;
        if (rdy) begin
            if (wb_s.we && wb_s.rd != 0) env_rf[wb_s.rd] = wb_s.res;
            wb_s = mem_s;
            mem_s = fire_ex ? b_res : bub;
        end
        can_b = !m_b || rdy;
        moved = can_b && m_a && !fl;
        if (can_b) begin
            m_b = moved;
            if (moved) b_res = execute(a_ins);
        end
        if (fl) m_a = 0;
        else if (fired) begin
            m_a = 1;
            a_ins = ins;
        end else if (moved) m_a = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, DW'(bus.ex_valid_o), '0);
        chk({tag, "_result"}, bus.ex_result_o, '0);
        chk({tag, "_rt"}, bus.ex_rt_data_o, '0);
        chk({tag, "_rd"}, DW'(bus.ex_rd_addr_o), '0);
        chk({tag, "_we"}, DW'(bus.ex_reg_write_o), '0);
        chk({tag, "_ready"}, DW'(bus.id_ready_o), 1);
    endtask

    task automatic do_reset_async();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("arst");
        bus.id_valid_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_a = 0;
        m_b = 0;
        mem_s = bub;
        wb_s = bub;
        arch = env_rf;
    endtask

    task automatic idle(input int n);
        bit f;
        for (int k = 0; k < n; k++) step(0, mk(0, 0, 0, 0, 0, 0, 0), 0, 1, f);
    endtask

    function automatic instr_t rnd_instr();
        return mk(4'($urandom_range(0, 8)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  (($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 7))
                                               : DW'($urandom)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    endfunction

    initial begin
        bit f;
        bit have;
        instr_t cur;
        bub = '{res: '0, rtd: '0, rd: '0, we: 1'b0};
        mem_s = bub;
        wb_s = bub;
        m_a = 0;
        m_b = 0;
        env_rf[0] = '0;
        for (int i = 1; i < 32; i++) env_rf[i] = $urandom;
        bus.id_valid_i = 0; bus.id_alu_op_i = '0; bus.id_rs_addr_i = '0;
        bus.id_rt_addr_i = '0; bus.id_rs_data_i = '0; bus.id_rt_data_i = '0;
        bus.id_imm_i = '0; bus.id_use_imm_i = 0; bus.id_rd_addr_i = '0;
        bus.id_reg_write_i = 0; bus.flush_i = 0; bus.ex_ready_i = 1;
        bus.mem_reg_write_i = 0; bus.mem_rd_addr_i = '0; bus.mem_result_i = '0;
        bus.wb_reg_write_i = 0; bus.wb_rd_addr_i = '0; bus.wb_result_i = '0;
        #1;
        chk_reset_outs("rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        env_rf[1] = 17;
        env_rf[2] = 17;
        arch = env_rf;
        step(1, mk(ALUOP_ADD, 1, 2, 3, 0, 0, 1), 0, 1, f);
        idle(1);
        chk("add_valid", DW'(bus.ex_valid_o), 1);
        chk("add_res", bus.ex_result_o, 34);
        chk("add_rd", DW'(bus.ex_rd_addr_o), 3);

        env_rf[1] = 5;
        env_rf[2] = 7;
        arch[1] = 5;
        arch[2] = 7;
        step(1, mk(ALUOP_ADD, 1, 2, 3, 0, 0, 1), 0, 1, f);
        step(1, mk(ALUOP_SUB, 3, 0, 4, 2, 1, 1), 0, 1, f);
        chk("fwd_add", bus.ex_result_o, 12);
        step(1, mk(ALUOP_OR, 4, 3, 5, 0, 0, 1), 0, 1, f);
        chk("fwd_sub", bus.ex_result_o, 10);
        step(1, mk(ALUOP_NOR, 5, 4, 6, 0, 0, 1), 0, 1, f);
        step(1, mk(ALUOP_AND, 6, 3, 7, 0, 0, 1), 0, 1, f);
        step(1, mk(ALUOP_SLT, 6, 7, 8, 0, 0, 1), 0, 1, f);
        idle(4);

        step(1, mk(ALUOP_ADD, 0, 0, 5, 32'h5555, 1, 1), 0, 1, f);
        step(1, mk(ALUOP_ADD, 0, 0, 5, 32'hAAAA, 1, 1), 0, 1, f);
        idle(1);
        step(1, mk(ALUOP_ADD, 5, 0, 6, 0, 1, 1), 0, 1, f);
        idle(1);
        chk("mem_over_wb", bus.ex_result_o, 32'hAAAA);
        step(1, mk(ALUOP_ADD, 0, 0, 0, 32'h1234, 1, 1), 0, 1, f);
        idle(1);
        step(1, mk(ALUOP_OR, 0, 0, 7, 0, 0, 1), 0, 1, f);
        idle(1);
        chk("r0_nofwd", bus.ex_result_o, 0);
        idle(3);

        step(1, mk(ALUOP_ADD, 1, 2, 9, 0, 0, 1), 0, 1, f);
        step(1, mk(ALUOP_SUB, 9, 1, 10, 0, 0, 1), 0, 1, f);
        for (int k = 0; k < 3; k++) begin
            step(1, mk(ALUOP_XOR, 10, 9, 11, 0, 0, 1), 0, 0, f);
            chk("stall_ready", DW'(bus.id_ready_o), 0);
        end
        f = 0;
        for (int k = 0; k < 4 && !f; k++)
            step(1, mk(ALUOP_XOR, 10, 9, 11, 0, 0, 1), 0, 1, f);
        chk("stall_release", DW'(f), 1);
        idle(4);

        step(1, mk(ALUOP_ADD, 1, 1, 12, 0, 0, 1), 0, 1, f);
        step(1, mk(ALUOP_ADD, 12, 1, 13, 0, 0, 1), 0, 1, f);
        step(1, mk(ALUOP_ADD, 13, 1, 14, 0, 0, 1), 1, 1, f);
        chk("flush_kill", DW'(bus.ex_valid_o), 0);
        idle(2);
        chk("flush_empty", DW'(bus.ex_valid_o), 0);

        step(1, mk(ALUOP_ADD, 1, 1, 15, 0, 0, 1), 0, 1, f);
        step(1, mk(ALUOP_ADD, 15, 1, 16, 0, 0, 1), 0, 1, f);
        step(1, mk(ALUOP_ADD, 16, 1, 17, 0, 0, 1), 0, 0, f);
        do_reset_async();
        idle(2);

        have = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!have) begin
                cur = rnd_instr();
                have = ($urandom_range(0, 3) != 0);
            end
            step(have, cur, ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), f);
            if (f) have = 0;
            if ($urandom_range(0, 499) == 0) begin
                do_reset_async();
                have = 0;
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
